// File: rtl/vga_pattern_src.sv
// vga_pattern_src: test-pattern pixel source for the VGA timing stage.
// Takes active-pixel coordinates and DE, and returns 10-bit R/G/B exactly
// two clock edges later. Four patterns (bars, scrolling checker, grey ramp,
// solid colour) are selected by a mode that only switches at frame start.
// Optional build macro: PATGEN_BORDER_EN adds a 1-pixel white frame border.
module vga_pattern_src #(
  parameter int         H_ACTIVE  = 640,
  parameter int         V_ACTIVE  = 480,
  parameter int         BAR_W     = 80,
  parameter int         CHK_SHIFT = 5,
  parameter logic [9:0] SOLID_R   = 10'h3FF,
  parameter logic [9:0] SOLID_G   = 10'h000,
  parameter logic [9:0] SOLID_B   = 10'h000
) (
  input  logic       iCLK,
  input  logic       rst,
  input  logic [9:0] iCoord_X,
  input  logic [9:0] iCoord_Y,
  input  logic       iDE,
  input  logic [1:0] iMode,
  input  logic       iMode_Valid,
  output logic [9:0] oRed,
  output logic [9:0] oGreen,
  output logic [9:0] oBlue,
  output logic       oValid,
  output logic [1:0] oMode,
  output logic [7:0] oFrame_Cnt
);

  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  // Bar colours left to right as {R,G,B} on/off bits; index 8 (past the
  // last bar) is black.
  function automatic logic [2:0] bar_code(input logic [3:0] idx);
    case (idx)
      4'd0:    return 3'b111;  // white
      4'd1:    return 3'b110;  // yellow
      4'd2:    return 3'b011;  // cyan
      4'd3:    return 3'b010;  // green
      4'd4:    return 3'b101;  // magenta
      4'd5:    return 3'b100;  // red
      4'd6:    return 3'b001;  // blue
      default: return 3'b000;  // black
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  pend_q, pend_d;
  logic [1:0]  mode_d;
  logic [7:0]  cnt_d;
  logic        frame_start;

  // Stage-1 pipeline registers and their combinational inputs.
  logic [9:0]  s1_x;
  logic        s1_de, s1_draw, s1_inr, s1_chk;
  logic [3:0]  s1_bar, bar_idx;
  logic        chk_bit, in_range;
`ifdef PATGEN_BORDER_EN
  logic [9:0]  s1_y;
`endif

  logic [2:0]  bar_c;
  logic [29:0] pix_rgb;

  assign frame_start = iDE && (iCoord_X == 10'd0) && (iCoord_Y == 10'd0);

  // Next state, pending mode, drawn mode and frame counter.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = oMode;
    cnt_d   = oFrame_Cnt;
    // A strobe in the frame_start cycle itself is visible to that frame.
    pend_d  = iMode_Valid ? iMode : pend_q;
    case (state_q)
      WAIT_FRAME: begin
        if (frame_start) begin
          state_d = ACTIVE;
          mode_d  = pend_d;
          cnt_d   = oFrame_Cnt + 8'd1;
        end
      end
      ACTIVE: begin
        if (frame_start) begin
          mode_d = pend_d;
          cnt_d  = oFrame_Cnt + 8'd1;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  // Control registers: FSM state, pending mode, drawn mode, frame count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge iCLK) begin
    if (rst) begin
      state_q    <= WAIT_FRAME;
      pend_q     <= 2'd0;
      oMode      <= 2'd0;
      oFrame_Cnt <= 8'd0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      oMode      <= mode_d;
      oFrame_Cnt <= cnt_d;
    end
  end

  // Bar index by a comparator chain against multiples of BAR_W.
  always_comb begin
    bar_idx = 4'd0;
    for (int i = 1; i <= 8; i++) begin
      if ({1'b0, iCoord_X} >= 11'(i * BAR_W)) bar_idx = bar_idx + 4'd1;
    end
  end

  // Checker uses the count of the frame this pixel belongs to (cnt_d), so the
  // frame_start pixel already scrolls with the rest of its frame.
  assign chk_bit  = 1'(({1'b0, iCoord_X} + {3'b0, cnt_d}) >> CHK_SHIFT)
                    ^ iCoord_Y[CHK_SHIFT];
  assign in_range = (iCoord_X <= X_LAST) && (iCoord_Y <= Y_LAST);

  // Stage 1: register coordinates, DE, draw enable and pattern features.
  always_ff @(posedge iCLK) begin
    if (rst) begin
      s1_x    <= 10'd0;
      s1_de   <= 1'b0;
      s1_draw <= 1'b0;
      s1_inr  <= 1'b0;
      s1_chk  <= 1'b0;
      s1_bar  <= 4'd0;
`ifdef PATGEN_BORDER_EN
      s1_y    <= 10'd0;
`endif
    end else begin
      s1_x    <= iCoord_X;
      s1_de   <= iDE;
      s1_draw <= frame_start || (state_q == ACTIVE);
      s1_inr  <= in_range;
      s1_chk  <= chk_bit;
      s1_bar  <= bar_idx;
`ifdef PATGEN_BORDER_EN
      s1_y    <= iCoord_Y;
`endif
    end
  end

  assign bar_c = bar_code(s1_bar);

  // Stage-2 colour select; oMode already holds this pixel's frame mode.
  always_comb begin
    pix_rgb = 30'd0;
    if (s1_de && s1_draw && s1_inr) begin
      case (oMode)
        2'd0:    pix_rgb = {{10{bar_c[2]}}, {10{bar_c[1]}}, {10{bar_c[0]}}};
        2'd1:    pix_rgb = {30{s1_chk}};
        2'd2:    pix_rgb = {s1_x, s1_x, s1_x};
        default: pix_rgb = {SOLID_R, SOLID_G, SOLID_B};
      endcase
`ifdef PATGEN_BORDER_EN
      if (s1_x == 10'd0 || s1_x == X_LAST || s1_y == 10'd0 || s1_y == Y_LAST)
        pix_rgb = {30{1'b1}};
`endif
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge iCLK) begin
    if (rst) begin
      {oRed, oGreen, oBlue} <= 30'd0;
      oValid                <= 1'b0;
    end else begin
      {oRed, oGreen, oBlue} <= pix_rgb;
      oValid                <= s1_de;
    end
  end

endmodule

// File: tb/tb_vga_pattern_src.sv
// tb_vga_pattern_src: table-driven bench for vga_pattern_src with a
// two-deep scoreboard queue matching the fixed pixel latency.
module tb_vga_pattern_src;

  localparam logic [9:0] W = 10'h3FF;
  localparam logic [9:0] Z = 10'h000;

  logic       iCLK = 1'b0;
  logic       rst;
  logic [9:0] iCoord_X, iCoord_Y;
  logic       iDE, iMode_Valid;
  logic [1:0] iMode;
  logic [9:0] oRed, oGreen, oBlue;
  logic       oValid;
  logic [1:0] oMode;
  logic [7:0] oFrame_Cnt;

  vga_pattern_src dut (
    .iCLK       (iCLK),
    .rst        (rst),
    .iCoord_X   (iCoord_X),
    .iCoord_Y   (iCoord_Y),
    .iDE        (iDE),
    .iMode      (iMode),
    .iMode_Valid(iMode_Valid),
    .oRed       (oRed),
    .oGreen     (oGreen),
    .oBlue      (oBlue),
    .oValid     (oValid),
    .oMode      (oMode),
    .oFrame_Cnt (oFrame_Cnt)
  );

  always #20 iCLK = ~iCLK;

  typedef struct {
    logic [9:0] x, y;
    logic       de, mv;
    logic [1:0] mode;
    logic       drw;   // pixel is drawn in range (border may override)
    logic       ev;
    logic [9:0] r, g, b;
  } vec_t;

  typedef struct {
    logic        chk;
    logic [30:0] exp;
    int          tag;
  } sb_t;

  sb_t  sb_q[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [9:0] x, y, input logic de, mv,
                              input logic [1:0] mode, input logic drw, ev,
                              input logic [9:0] r, g, b);
    vec_t v;
    v.x = x; v.y = y; v.de = de; v.mv = mv; v.mode = mode;
    v.drw = drw; v.ev = ev; v.r = r; v.g = g; v.b = b;
    return v;
  endfunction

  function automatic logic [29:0] border_adj(input logic [9:0] x, y, input logic drw,
                                             input logic [29:0] rgb);
`ifdef PATGEN_BORDER_EN
    if (drw && (x == 10'd0 || x == 10'd639 || y == 10'd0 || y == 10'd479))
      return {30{1'b1}};
`endif
    return rgb;
  endfunction

  // Checker expectation straight from the pattern definition.
  function automatic logic [29:0] chk_rgb(input logic [9:0] x, y, input logic [7:0] c);
    logic [10:0] s;
    s = {1'b0, x} + {3'b0, c};
    return {30{s[5] ^ y[5]}};
  endfunction

  // One pixel clock: compare the entry driven two cycles ago, then drive.
  task automatic step(input logic [9:0] x, y, input logic de, mv, input logic [1:0] mode,
                      input logic chk, drw, ev, input logic [29:0] rgb, input int tag);
    sb_t e, got;
    @(negedge iCLK);
    if (sb_q.size() == 2) begin
      got = sb_q.pop_front();
      if (got.chk)
        check($sformatf("pix%0d", got.tag), {oValid, oRed, oGreen, oBlue}, got.exp);
    end
    iCoord_X = x; iCoord_Y = y; iDE = de; iMode_Valid = mv; iMode = mode;
    e.chk = chk;
    e.exp = {ev, border_adj(x, y, drw, rgb)};
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int tag);
    step(10'd0, 10'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 30'd0, tag);
  endtask

  initial begin
    rst = 1'b1; iCoord_X = '0; iCoord_Y = '0; iDE = 1'b0; iMode = '0; iMode_Valid = 1'b0;

    // Stimulus table: bars frame, ramp mid-frame strobe, solid, same-cycle strobe.
    tbl.push_back(mk(  1,   1, 0, 1, 0, 0, 0, Z, Z, Z)); // strobe mode 0
    tbl.push_back(mk(  0,   0, 1, 0, 0, 1, 1, W, W, W)); // frame 1, white
    tbl.push_back(mk( 79,   0, 1, 0, 0, 1, 1, W, W, W));
    tbl.push_back(mk( 80,   0, 1, 0, 0, 1, 1, W, W, Z)); // yellow
    tbl.push_back(mk(160,   0, 1, 0, 0, 1, 1, Z, W, W)); // cyan
    tbl.push_back(mk(240,   0, 1, 0, 0, 1, 1, Z, W, Z)); // green
    tbl.push_back(mk(320,   0, 1, 0, 0, 1, 1, W, Z, W)); // magenta
    tbl.push_back(mk(400,   0, 1, 0, 0, 1, 1, W, Z, Z)); // red
    tbl.push_back(mk(480,   0, 1, 0, 0, 1, 1, Z, Z, W)); // blue
    tbl.push_back(mk(560,   0, 1, 0, 0, 1, 1, Z, Z, Z)); // black
    tbl.push_back(mk(639,   0, 1, 0, 0, 1, 1, Z, Z, Z));
    tbl.push_back(mk(700,   3, 1, 0, 0, 0, 1, Z, Z, Z)); // X out of range
    tbl.push_back(mk( 10, 500, 1, 0, 0, 0, 1, Z, Z, Z)); // Y out of range
    tbl.push_back(mk( 10,   1, 0, 0, 0, 0, 0, Z, Z, Z)); // DE low
    tbl.push_back(mk(100,   1, 1, 1, 2, 1, 1, W, W, Z)); // strobe ramp, still bars
    tbl.push_back(mk(100,   2, 1, 0, 0, 1, 1, W, W, Z));
    tbl.push_back(mk(  0,   0, 1, 0, 0, 1, 1, Z, Z, Z)); // frame 2, ramp
    tbl.push_back(mk(100,   3, 1, 0, 0, 1, 1, 10'd100, 10'd100, 10'd100));
    tbl.push_back(mk(  5,   1, 1, 1, 3, 1, 1, 10'd5, 10'd5, 10'd5)); // strobe solid
    tbl.push_back(mk(100,   2, 1, 0, 0, 1, 1, 10'd100, 10'd100, 10'd100));
    tbl.push_back(mk(  0,   0, 1, 0, 0, 1, 1, W, Z, Z)); // frame 3, solid red
    tbl.push_back(mk(  5,   5, 1, 0, 0, 1, 1, W, Z, Z));
    tbl.push_back(mk(639,   5, 1, 0, 0, 1, 1, W, Z, Z));
    tbl.push_back(mk(  5, 479, 1, 0, 0, 1, 1, W, Z, Z));
    tbl.push_back(mk(  0,   5, 1, 0, 0, 1, 1, W, Z, Z));
    tbl.push_back(mk(  3,   3, 1, 1, 1, 1, 1, W, Z, Z)); // pending checker
    tbl.push_back(mk(  0,   0, 1, 1, 3, 1, 1, W, Z, Z)); // same-cycle strobe wins
    tbl.push_back(mk(  5,   0, 1, 0, 0, 1, 1, W, Z, Z));
    tbl.push_back(mk(  1,   1, 1, 0, 0, 1, 1, W, Z, Z));
    tbl.push_back(mk(1023, 1023, 1, 0, 0, 0, 1, Z, Z, Z));

    // Reset state.
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_rgb",   {oRed, oGreen, oBlue}, 30'd0);
    check("rst_valid", oValid, 1'b0);
    check("rst_mode",  oMode, 2'd0);
    check("rst_cnt",   oFrame_Cnt, 8'd0);
    rst = 1'b0;

    // Before any frame_start: DE tracked, pixels black.
    step(10'd5, 10'd5, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 30'd0, 900);

    foreach (tbl[i]) begin
      step(tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].mv, tbl[i].mode, 1'b1,
           tbl[i].drw, tbl[i].ev, {tbl[i].r, tbl[i].g, tbl[i].b}, i);
      if (i == 2) check("cnt_frame1", oFrame_Cnt, 8'd1);
    end
    idle(901);
    idle(902);
    check("mode_after_tbl", oMode, 2'd3);
    check("cnt_after_tbl",  oFrame_Cnt, 8'd4);

    // Checker: strobe, then exact mode switch at the frame_start edge.
    step(10'd3, 10'd3, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, {W, Z, Z}, 950);
    step(10'd0, 10'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 30'd0, 951);
    check("mode_before_fs", oMode, 2'd3);
    @(posedge iCLK);
    #1;
    check("mode_at_fs", oMode, 2'd1);
    exp_cnt = 8'd5;
    check("cnt_at_fs", oFrame_Cnt, exp_cnt);
    step(10'd31, 10'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, chk_rgb(10'd31, 10'd0, exp_cnt), 952);

    // 256 short frames: counter wraps, checker scrolls with the count.
    for (int f = 0; f < 256; f++) begin
      step(10'd0, 10'd0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 30'd0, 1000 + 3 * f);
      exp_cnt = exp_cnt + 8'd1;
      step(10'd31, 10'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1,
           chk_rgb(10'd31, 10'd0, exp_cnt), 1001 + 3 * f);
      step(10'd32, 10'd32, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1,
           chk_rgb(10'd32, 10'd32, exp_cnt), 1002 + 3 * f);
      check($sformatf("frame_cnt%0d", f), oFrame_Cnt, exp_cnt);
    end
    idle(1900);
    idle(1901);

    // Mid-frame reset at (300,200) of a bars frame.
    step(10'd1, 10'd1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 30'd0, 2000);
    step(10'd0, 10'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, {W, W, W}, 2001);
    step(10'd299, 10'd200, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, {Z, W, Z}, 2002);
    @(negedge iCLK);
    begin
      sb_t got;
      got = sb_q.pop_front();
      check("pix2001", {oValid, oRed, oGreen, oBlue}, got.exp);
    end
    sb_q.delete();
    iCoord_X = 10'd300; iCoord_Y = 10'd200; iDE = 1'b1;
    rst = 1'b1;
    @(posedge iCLK);
    #1;
    check("mrst_valid", oValid, 1'b0);
    check("mrst_rgb",   {oRed, oGreen, oBlue}, 30'd0);
    check("mrst_cnt",   oFrame_Cnt, 8'd0);
    check("mrst_mode",  oMode, 2'd0);
    rst = 1'b0;
    step(10'd301, 10'd200, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 30'd0, 2010);
    step(10'd400, 10'd200, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 30'd0, 2011);
    step(10'd639, 10'd479, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 30'd0, 2012);
    step(10'd0, 10'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, {W, W, W}, 2013);
    step(10'd80, 10'd0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, {W, W, Z}, 2014);
    step(10'd100, 10'd5, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, {W, W, Z}, 2015);
    idle(2016);
    idle(2017);
    check("post_rst_cnt",  oFrame_Cnt, 8'd1);
    check("post_rst_mode", oMode, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
